// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the display path: canonical hex glyph
// table, blank constant and the reverse (segments -> nibble) decoder.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Index is the hex digit; bits are segments g..a.
    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic             hit;
        logic [NIB_W-1:0] nibble;
    } seg_dec_t;

    function automatic seg_dec_t seg_decode(input logic [SEG_W-1:0] seg);
        seg_dec_t r;
        r.hit    = 1'b0;
        r.nibble = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i]) begin
                r.hit    = 1'b1;
                r.nibble = NIB_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/nib_fifo.sv
// Small nibble FIFO with wrap-bit pointers; head is presented combinationally
// and a push into a full FIFO without a same-cycle pop sets a sticky ovf.
module nib_fifo
    import seg7_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = NIB_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             pop_ok;
    logic             push_ok;

    // A pop frees a slot, so a full FIFO can still accept a same-cycle push.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        pop_ok   = pop && !empty_q;
        push_ok  = push && (!full_q || pop_ok);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q[AW-1:0]] = wdata;
                wr_ptr_d                = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !push_ok) begin
                ovf_d = 1'b1;
            end
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                  (wr_ptr_d[AW] != rd_ptr_d[AW]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

    assign rdata = empty_q ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign full  = full_q;
    assign empty = empty_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/seg_pattern_rx.sv
// Receive side of the seven-segment path: debounces the segment bus, decodes
// each newly stable pattern to a hex nibble and queues it for the debug outputs.
module seg_pattern_rx
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic [7:0] seg_in,
    input  logic       rd_en,
    input  logic       clear,
    output logic [3:0] nibble_out,
    output logic       valid,
    output logic       full,
    output logic       dp_out,
    output logic       err,
    output logic       ovf,
    output logic [3:0] err_count
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [7:0]       seg_q, seg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic [SEG_W-1:0] last_acc_q, last_acc_d;
    logic             dp_q, dp_d;
    logic             err_q, err_d;
    logic [3:0]       err_cnt_q, err_cnt_d;

    logic             changed_c;
    logic             accept_c;
    logic             fresh_c;
    logic             push_c;
    logic             bad_c;
    seg_dec_t         dec_c;
    logic             fifo_empty;

    // Debounce, accept and decode; a push rides the same edge as the accept.
    always_comb begin
        seg_d      = seg_in;
        cnt_d      = cnt_q;
        armed_d    = armed_q;
        last_acc_d = last_acc_q;
        dp_d       = dp_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;

        changed_c = (seg_in != seg_q);
        accept_c  = armed_q && !changed_c && (cnt_q == CNT_LAST);
        dec_c     = seg_decode(seg_q[SEG_W-1:0]);
        fresh_c   = accept_c && (seg_q[SEG_W-1:0] != last_acc_q) &&
                    (seg_q[SEG_W-1:0] != SEG_BLANK);
        push_c    = fresh_c && dec_c.hit && !clear;
        bad_c     = fresh_c && !dec_c.hit;

        if (changed_c) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (accept_c) begin
            armed_d = 1'b0;
        end else if (armed_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (accept_c) begin
            last_acc_d = seg_q[SEG_W-1:0];
            dp_d       = seg_q[7];
        end

        if (clear) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end else if (bad_c) begin
            err_d = 1'b1;
            if (err_cnt_q != 4'hF) begin
                err_cnt_d = err_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_2) begin
        if (!reset) begin
            seg_q      <= '0;
            cnt_q      <= '0;
            armed_q    <= 1'b0;
            last_acc_q <= '0;
            dp_q       <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            seg_q      <= seg_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            last_acc_q <= last_acc_d;
            dp_q       <= dp_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    nib_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (NIB_W)
    ) u_fifo (
        .clk   (clk_2),
        .rst_n (reset),
        .push  (push_c),
        .wdata (dec_c.nibble),
        .pop   (rd_en),
        .clear (clear),
        .rdata (nibble_out),
        .full  (full),
        .empty (fifo_empty),
        .ovf   (ovf)
    );

    assign valid     = !fifo_empty;
    assign dp_out    = dp_q;
    assign err       = err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_seg_pattern_rx.sv
// Scenario bench for seg_pattern_rx: expected nibbles are queued as patterns
// are driven and compared against the FIFO head as it is popped.
module tb_seg_pattern_rx;

    logic       clk_2;
    logic       reset;
    logic [7:0] seg_in;
    logic       rd_en;
    logic       clear;
    logic [3:0] nibble_out;
    logic       valid;
    logic       full;
    logic       dp_out;
    logic       err;
    logic       ovf;
    logic [3:0] err_count;

    int total = 0;
    int bad   = 0;
    logic [3:0] sb [$];

    logic [6:0] tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seg_pattern_rx #(.STABLE_CYCLES(3), .FIFO_DEPTH(4)) dut (
        .clk_2      (clk_2),
        .reset      (reset),
        .seg_in     (seg_in),
        .rd_en      (rd_en),
        .clear      (clear),
        .nibble_out (nibble_out),
        .valid      (valid),
        .full       (full),
        .dp_out     (dp_out),
        .err        (err),
        .ovf        (ovf),
        .err_count  (err_count)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic present(input logic [7:0] p, input int n);
        seg_in = p;
        repeat (n) tick();
    endtask

    task automatic pop_head(output logic [3:0] got);
        got   = nibble_out;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic sb_take(output logic [3:0] e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = 4'hx;
    endtask

    function automatic bit in_tab(input logic [6:0] v);
        for (int i = 0; i < 16; i++) if (tab[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset();
        reset = 1'b0; seg_in = 8'h00; rd_en = 1'b0; clear = 1'b0;
        repeat (2) tick();
        total++; if (nibble_out !== 4'h0) begin bad++; $display("FAIL rst_nibble got=%h exp=0", nibble_out); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", full); end
        total++; if (dp_out !== 1'b0) begin bad++; $display("FAIL rst_dp got=%b exp=0", dp_out); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
        total++; if (err_count !== 4'h0) begin bad++; $display("FAIL rst_errcnt got=%0d exp=0", err_count); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [3:0] e, got;
        seg_in = 8'h5B;
        sb.push_back(4'h2);
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++;
            if (valid !== (k == 4)) begin bad++; $display("FAIL basic_latency cycle=%0d got=%b exp=%b", k, valid, (k == 4)); end
        end
        total++; if (dp_out !== 1'b0) begin bad++; $display("FAIL basic_dp got=%b exp=0", dp_out); end
        repeat (2) tick();
        sb_take(e);
        pop_head(got);
        total++; if (got !== e) begin bad++; $display("FAIL basic_nibble got=%h exp=%h", got, e); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL basic_empty got=%b exp=0", valid); end
    endtask

    task automatic test_glitch();
        logic [3:0] e, got;
        sb.push_back(4'h4);
        present(8'h66, 5);
        present(8'h6D, 1);
        present(8'h66, 6);
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL glitch_valid got=%b exp=1", valid); end
        sb_take(e);
        pop_head(got);
        total++; if (got !== e) begin bad++; $display("FAIL glitch_nibble got=%h exp=%h", got, e); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL glitch_single got=%b exp=0", valid); end
    endtask

    task automatic test_overflow();
        logic [7:0] pats [5] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66};
        logic [3:0] e, got;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) sb.push_back(4'(i));
            present(pats[i], 5);
            if (i == 2) begin
                total++; if (full !== 1'b0) begin bad++; $display("FAIL ovf_notfull got=%b exp=0", full); end
            end
            if (i == 3) begin
                total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full4 got=%b exp=1", full); end
                total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", ovf); end
            end
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full5 got=%b exp=1", full); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
        for (int i = 0; i < 4; i++) begin
            total++; if (valid !== 1'b1) begin bad++; $display("FAIL ovf_pop_valid idx=%0d got=%b exp=1", i, valid); end
            sb_take(e);
            pop_head(got);
            total++; if (got !== e) begin bad++; $display("FAIL ovf_pop idx=%0d got=%h exp=%h", i, got, e); end
        end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b exp=0", valid); end
    endtask

    task automatic test_invalid();
        int n;
        int exp_cnt;
        present(8'h7E, 5);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL inv_err got=%b exp=1", err); end
        total++; if (err_count !== 4'd1) begin bad++; $display("FAIL inv_cnt1 got=%0d exp=1", err_count); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL inv_valid got=%b exp=0", valid); end
        n = 0;
        for (int v = 1; v < 128 && n < 16; v++) begin
            if (!in_tab(7'(v)) && (7'(v) != 7'h7E)) begin
                present({1'b0, 7'(v)}, 5);
                n++;
                exp_cnt = (1 + n > 15) ? 15 : 1 + n;
                total++;
                if (err_count !== 4'(exp_cnt)) begin bad++; $display("FAIL inv_sat pat=%h got=%0d exp=%0d", v, err_count, exp_cnt); end
            end
        end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL inv_noqueue got=%b exp=0", valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pats [4] = '{8'h77, 8'h7C, 8'h39, 8'h5E};
        logic [3:0] e, got;
        clear = 1'b1; tick(); clear = 1'b0;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL clr1_err got=%b exp=0", err); end
        total++; if (err_count !== 4'd0) begin bad++; $display("FAIL clr1_cnt got=%0d exp=0", err_count); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL clr1_ovf got=%b exp=0", ovf); end
        for (int i = 0; i < 4; i++) begin
            sb.push_back(4'(10 + i));
            present(pats[i], 5);
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL b2b_full got=%b exp=1", full); end
        seg_in = 8'h79;
        sb.push_back(4'hE);
        repeat (3) tick();
        sb_take(e);
        pop_head(got);
        total++; if (got !== e) begin bad++; $display("FAIL b2b_head got=%h exp=%h", got, e); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL b2b_stillfull got=%b exp=1", full); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%b exp=0", ovf); end
        for (int i = 0; i < 4; i++) begin
            sb_take(e);
            pop_head(got);
            total++; if (got !== e) begin bad++; $display("FAIL b2b_pop idx=%0d got=%h exp=%h", i, got, e); end
        end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", valid); end
        sb.push_back(4'hF);
        present(8'h71, 5);
        present(8'hFE, 5);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL clr2_preerr got=%b exp=1", err); end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL clr2_prevalid got=%b exp=1", valid); end
        clear = 1'b1; tick(); clear = 1'b0;
        sb.delete();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL clr2_valid got=%b exp=0", valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL clr2_err got=%b exp=0", err); end
        total++; if (err_count !== 4'd0) begin bad++; $display("FAIL clr2_cnt got=%0d exp=0", err_count); end
        total++; if (dp_out !== 1'b1) begin bad++; $display("FAIL clr2_dp got=%b exp=1", dp_out); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e, got;
        sb.push_back(4'h0);
        present(8'h3F, 5);
        sb.push_back(4'h1);
        present(8'h86, 5);
        total++; if (dp_out !== 1'b1) begin bad++; $display("FAIL mid_predp got=%b exp=1", dp_out); end
        seg_in = 8'h5B;
        repeat (2) tick();
        reset = 1'b0; tick(); reset = 1'b1;
        sb.delete();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", valid); end
        total++; if (nibble_out !== 4'h0) begin bad++; $display("FAIL mid_nibble got=%h exp=0", nibble_out); end
        total++; if (dp_out !== 1'b0) begin bad++; $display("FAIL mid_dp got=%b exp=0", dp_out); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL mid_full got=%b exp=0", full); end
        sb.push_back(4'h2);
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++;
            if (valid !== (k == 4)) begin bad++; $display("FAIL mid_relatency cycle=%0d got=%b exp=%b", k, valid, (k == 4)); end
        end
        sb_take(e);
        pop_head(got);
        total++; if (got !== e) begin bad++; $display("FAIL mid_nibble2 got=%h exp=%h", got, e); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_overflow();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
